pc_gen: RTL and testbench

Parametrised next-generation PC unit: owns the architectural PC register instead of only computing next-PC combinationally. Supports sequential, branch, jump and jump-register modes, an exception vector with EPC capture, and eret. Provides a valid/ready fetch handshake to instruction memory and holds a pending redirect across stalls. Sits between decode/control and the fetch stage of the MIPS core.

---
 rtl/pc_gen.sv | 102 ++++++++++
 tb/tb_pc_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// PC generation unit: owns the architectural PC, resolves seq/branch/jump/jr targets,
// holds redirects across stalls, and handles exception entry (with EPC capture) and eret.
module pc_gen #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [1:0]        npc_op,
    input  logic              redir,
    input  logic [25:0]       d_ins26,
    input  logic [ADDR_W-1:0] d_ext32,
    input  logic [ADDR_W-1:0] d_reg32,
    input  logic              exc_req,
    input  logic              eret,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] epc,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VEC);

    typedef enum logic [1:0] {
        OP_SEQ    = 2'b00,
        OP_BRANCH = 2'b01,
        OP_JUMP   = 2'b10,
        OP_JR     = 2'b11
    } npc_op_e;

    logic [ADDR_W-1:0] pend_tgt;
    logic              pend_valid;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] target;
    logic              redirect;
    logic              misaligned_jr;
    logic              take_exc;
    logic              adv;

    assign seq_pc = pc + ADDR_W'(4);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        target = seq_pc;
        case (npc_op_e'(npc_op))
            OP_SEQ:    target = seq_pc;
            // Shift keeps the low ADDR_W bits only, i.e. {d_ext32[ADDR_W-3:0], 2'b00}.
            OP_BRANCH: target = pc + (d_ext32 << 2);
            OP_JUMP:   target = {pc[ADDR_W-1:28], d_ins26, 2'b00};
            OP_JR:     target = d_reg32;
            default:   target = seq_pc;
        endcase
    end

    assign redirect      = redir && (npc_op != OP_SEQ);
    assign misaligned_jr = redir && (npc_op == OP_JR) && (d_reg32[1:0] != 2'b00);
    assign take_exc      = exc_req || misaligned_jr;
    assign adv           = fetch_valid && fetch_ready && !stall;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            epc         <= '0;
            fetch_valid <= 1'b0;
            addr_err    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_tgt    <= '0;
        end else begin
            fetch_valid <= 1'b1;
            addr_err    <= 1'b0;
            if (take_exc) begin
                epc        <= pc;
                pc         <= EXC_PC;
                pend_valid <= 1'b0;
                addr_err   <= misaligned_jr;
            end else if (eret) begin
                pc         <= epc;
                pend_valid <= 1'b0;
            end else if (adv) begin
                if (pend_valid) begin
                    pc <= pend_tgt;
                    // A redirect arriving while the older one retires becomes the new pending one.
                    pend_valid <= redirect;
                    if (redirect) pend_tgt <= target;
                end else if (redirect) begin
                    pc <= target;
                end else begin
                    pc <= seq_pc;
                end
            end else if (redirect) begin
                pend_valid <= 1'b1;
                pend_tgt   <= target;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a spec-level model checked every cycle, plus directed
// literal expectations taken from the hand-worked scenarios.
module tb_pc_gen;

    localparam int          ADDR_W    = 32;
    localparam logic [31:0] RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic        redir = 1'b0;
    logic [25:0] d_ins26 = '0;
    logic [31:0] d_ext32 = '0;
    logic [31:0] d_reg32 = '0;
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic        fetch_ready = 1'b1;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        addr_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit done = 1'b0;

    pc_gen #(.ADDR_W(ADDR_W), .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .npc_op(npc_op), .redir(redir),
        .d_ins26(d_ins26), .d_ext32(d_ext32), .d_reg32(d_reg32), .exc_req(exc_req),
        .eret(eret), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .pc(pc),
        .epc(epc), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural state plus a queue of at most one pending target.
    logic [31:0] m_pc = RESET_VEC;
    logic [31:0] m_epc = '0;
    bit          m_fv = 1'b0;
    bit          m_aerr = 1'b0;
    logic [31:0] pend_q[$];
    logic [31:0] m_tgt;
    bit          m_redirect, m_misal, m_adv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = RESET_VEC; m_epc = 0; m_fv = 0; m_aerr = 0; pend_q.delete();
        end else begin
            m_aerr = 0;
            m_redirect = redir && npc_op != 2'd0;
            case (npc_op)
                2'd1:    m_tgt = m_pc + d_ext32 * 4;
                2'd2:    m_tgt = (m_pc & 32'hF000_0000) | (32'(d_ins26) * 4);
                2'd3:    m_tgt = d_reg32;
                default: m_tgt = m_pc + 4;
            endcase
            m_misal = redir && npc_op == 2'd3 && (d_reg32 % 4) != 0;
            m_adv = m_fv && fetch_ready && !stall;
            if (exc_req || m_misal) begin
                m_epc = m_pc; m_pc = EXC_VEC; pend_q.delete(); m_aerr = m_misal;
            end else if (eret) begin
                m_pc = m_epc; pend_q.delete();
            end else if (m_adv) begin
                if (pend_q.size() > 0) begin
                    m_pc = pend_q.pop_front();
                    if (m_redirect) pend_q.push_back(m_tgt);
                end else begin
                    m_pc = m_redirect ? m_tgt : m_pc + 4;
                end
            end else if (m_redirect) begin
                pend_q.delete(); pend_q.push_back(m_tgt);
            end
            m_fv = 1;
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!done) begin
            check("model_pc", pc, m_pc);
            check("model_epc", epc, m_epc);
            check("model_fetch_valid", 32'(fetch_valid), 32'(m_fv));
            check("model_addr_err", 32'(addr_err), 32'(m_aerr));
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_op(input logic [1:0] op);
        npc_op = op; redir = 1'b1;
    endtask

    task automatic clear_redirect();
        npc_op = 2'b00; redir = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] a);
        d_reg32 = a; redirect_op(2'd3);
        tick();
        clear_redirect();
    endtask

    initial begin
        tick(); tick();
        check("reset_pc", pc, 32'h3000);
        check("reset_fv", 32'(fetch_valid), 32'd0);
        rst_n = 1'b1;

        // Reset release: valid rises with pc unchanged, then sequential advance.
        tick(); check("rel_pc0", pc, 32'h3000); check("rel_fv", 32'(fetch_valid), 32'd1);
        tick(); check("seq_pc1", pc, 32'h3004);
        tick(); check("seq_pc2", pc, 32'h3008);
        tick(); tick(); check("seq_pc4", pc, 32'h3010);

        // Backward branch by 2 words, then absolute jump.
        d_ext32 = 32'hFFFF_FFFE; redirect_op(2'd1);
        tick(); check("branch_back", pc, 32'h3008);
        d_ins26 = 26'h0000C40; redirect_op(2'd2);
        tick(); check("jump_abs", pc, 32'h0000_3100);
        clear_redirect();

        // Redirect under stall is held pending until the stall drops.
        jump_to(32'h3020); check("jr_3020", pc, 32'h3020);
        stall = 1'b1; d_reg32 = 32'h3400; redirect_op(2'd3);
        tick(); clear_redirect();
        tick(); tick(); check("stall_hold", pc, 32'h3020);
        stall = 1'b0;
        tick(); check("pend_apply", pc, 32'h3400);
        tick(); check("pend_then_seq", pc, 32'h3404);

        // Misaligned jr becomes an exception.
        jump_to(32'h3050);
        d_reg32 = 32'h3402; redirect_op(2'd3);
        tick(); clear_redirect();
        check("misal_pc", pc, 32'h4180); check("misal_epc", epc, 32'h3050);
        check("misal_aerr", 32'(addr_err), 32'd1);
        tick(); check("aerr_pulse_end", 32'(addr_err), 32'd0);

        // Exception overrides stall and drops the pending redirect; eret returns.
        jump_to(32'h3060);
        stall = 1'b1; d_ext32 = 32'd4; redirect_op(2'd1);
        tick(); clear_redirect();
        exc_req = 1'b1;
        tick(); exc_req = 1'b0; stall = 1'b0;
        check("exc_pc", pc, 32'h4180); check("exc_epc", epc, 32'h3060);
        tick(); check("pend_dropped", pc, 32'h4184);
        eret = 1'b1;
        tick(); eret = 1'b0; check("eret_pc", pc, 32'h3060);

        // Simultaneous exc_req and eret: exception wins.
        exc_req = 1'b1; eret = 1'b1;
        tick(); exc_req = 1'b0; eret = 1'b0;
        check("exc_eret_pc", pc, 32'h4180); check("exc_eret_epc", epc, 32'h3060);

        // fetch_ready low holds pc; async reset mid-hold.
        jump_to(32'h3070);
        fetch_ready = 1'b0;
        tick(); tick(); check("ready_hold", pc, 32'h3070);
        #2 rst_n = 1'b0;
        #1 check("async_rst_pc", pc, 32'h3000); check("async_rst_fv", 32'(fetch_valid), 32'd0);
        fetch_ready = 1'b1;
        tick(); rst_n = 1'b1;
        tick(); tick(); check("post_rst_seq", pc, 32'h3004);

        // Wrap-around of pc+4 at the top of the address space.
        jump_to(32'hFFFF_FFFC); check("jr_top", pc, 32'hFFFF_FFFC);
        tick(); check("wrap_zero", pc, 32'h0000_0000);

        tick();
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
